// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the MEM/WB stage
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } mwb_state_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_IMM = 2'd1,
        WB_PCR = 2'd2,
        WB_MEM = 2'd3
    } wb_sel_t;

    // Registered copy of the DEX_* bundle.
    typedef struct packed {
        logic              alu_to_reg;
        logic              pcr_to_reg;
        logic              mem_to_reg;
        logic              imm_to_reg;
        logic              we_dst_0;
        logic              we_dst_1;
        logic              mem_we;
        logic              mem_re;
        logic              halt;
        logic [REG_AW-1:0] dst_addr_0;
        logic [REG_AW-1:0] dst_addr_1;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] pc_return;
        logic [DATA_W-1:0] load_immd;
        logic [DATA_W-1:0] reg_data_1;
        logic [DATA_W-1:0] mem_addr;
        logic [DATA_W-1:0] mem_wdata;
    } stage_t;

    // dst_0 source priority: memory > PC return > immediate > ALU.
    // The ALU is also the fallback when no select is raised.
    function automatic wb_sel_t wb_select(input logic mem, input logic pcr,
                                          input logic imm, input logic alu);
        wb_sel_t sel;
        sel = WB_ALU;
        if (mem)      sel = WB_MEM;
        else if (pcr) sel = WB_PCR;
        else if (imm) sel = WB_IMM;
        else if (alu) sel = WB_ALU;
        return sel;
    endfunction

endpackage

// File: rtl/mwb_wb_mux.sv
// rtl/mwb_wb_mux.sv - priority data select for the dst_0 register-file write port
// Ports:
//   mem_to_reg, pcr_to_reg, imm_to_reg, alu_to_reg  in  1   source selects
//   mem_rdata, pc_return, load_immd, alu_result     in  16  source candidates
//   wrt_data                                        out 16  selected dst_0 data
module mwb_wb_mux
    import cpu_pkg::*;
(
    input  logic              mem_to_reg,
    input  logic              pcr_to_reg,
    input  logic              imm_to_reg,
    input  logic              alu_to_reg,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] pc_return,
    input  logic [DATA_W-1:0] load_immd,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] wrt_data
);

    wb_sel_t sel;

    assign sel = wb_select(mem_to_reg, pcr_to_reg, imm_to_reg, alu_to_reg);

    always_comb begin
        wrt_data = alu_result;
        case (sel)
            WB_MEM:  wrt_data = mem_rdata;
            WB_PCR:  wrt_data = pc_return;
            WB_IMM:  wrt_data = load_immd;
            default: wrt_data = alu_result;
        endcase
    end

endmodule

// File: rtl/memory_writeback.sv
// rtl/memory_writeback.sv - CPU MEM/WB stage: stage register, data-memory handshake, writeback
// Ports:
//   clk, rst_n                       in   clock, asynchronous active-low reset
//   DEX_*                            in   instruction bundle from decode/execute
//   dmem_rdata, dmem_rdy             in   memory read data / completion
//   dmem_addr, dmem_wdata            out  memory address / store data
//   dmem_re, dmem_we                 out  memory request, held until dmem_rdy
//   MWB_dst_we_0/1, MWB_dst_addr_0/1 out  register-file write port controls
//   MWB_reg_0/1_wrt_data             out  register-file write data
//   MWB_STALL                        out  freeze upstream stages
//   MWB_halt, MWB_mem_err            out  sticky halt / memory-timeout flags
//   MWB_retired_cnt                  out  retired-instruction count (wraps)
module memory_writeback
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              DEX_alu_to_reg,
    input  logic              DEX_pcr_to_reg,
    input  logic              DEX_mem_to_reg,
    input  logic              DEX_imm_to_reg,
    input  logic              DEX_reg_we_dst_0,
    input  logic              DEX_reg_we_dst_1,
    input  logic              DEX_mem_we,
    input  logic              DEX_mem_re,
    input  logic              DEX_halt,
    input  logic [REG_AW-1:0] DEX_dst_addr_0,
    input  logic [REG_AW-1:0] DEX_dst_addr_1,
    input  logic [DATA_W-1:0] DEX_alu_result,
    input  logic [DATA_W-1:0] DEX_PC_return,
    input  logic [DATA_W-1:0] DEX_load_immd,
    input  logic [DATA_W-1:0] DEX_reg_data_1,
    input  logic [DATA_W-1:0] DEX_mem_read_addr,
    input  logic [DATA_W-1:0] DEX_mem_write_data,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_rdy,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_re,
    output logic              dmem_we,
    output logic              MWB_dst_we_0,
    output logic              MWB_dst_we_1,
    output logic [REG_AW-1:0] MWB_dst_addr_0,
    output logic [REG_AW-1:0] MWB_dst_addr_1,
    output logic [DATA_W-1:0] MWB_reg_0_wrt_data,
    output logic [DATA_W-1:0] MWB_reg_1_wrt_data,
    output logic              MWB_STALL,
    output logic              MWB_halt,
    output logic              MWB_mem_err,
    output logic [DATA_W-1:0] MWB_retired_cnt
);

    // Last MEM_WAIT cycle index: the request is abandoned after MEM_TIMEOUT wait cycles.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    stage_t     s_q;
    stage_t     s_d;
    mwb_state_t state_q;
    mwb_state_t state_d;
    logic [7:0] wait_q;
    logic [7:0] wait_d;
    logic       err_q;
    logic       err_d;
    logic [DATA_W-1:0] cnt_q;

    logic s_valid;
    logic mem_op;
    logic halted;
    logic stall;
    logic retire;
    logic dst_conflict;
    logic [DATA_W-1:0] wb_data_0;

    always_comb begin
        s_d            = '0;
        s_d.alu_to_reg = DEX_alu_to_reg;
        s_d.pcr_to_reg = DEX_pcr_to_reg;
        s_d.mem_to_reg = DEX_mem_to_reg;
        s_d.imm_to_reg = DEX_imm_to_reg;
        s_d.we_dst_0   = DEX_reg_we_dst_0;
        s_d.we_dst_1   = DEX_reg_we_dst_1;
        s_d.mem_we     = DEX_mem_we;
        s_d.mem_re     = DEX_mem_re;
        s_d.halt       = DEX_halt;
        s_d.dst_addr_0 = DEX_dst_addr_0;
        s_d.dst_addr_1 = DEX_dst_addr_1;
        s_d.alu_result = DEX_alu_result;
        s_d.pc_return  = DEX_PC_return;
        s_d.load_immd  = DEX_load_immd;
        s_d.reg_data_1 = DEX_reg_data_1;
        s_d.mem_addr   = DEX_mem_read_addr;
        s_d.mem_wdata  = DEX_mem_write_data;
    end

    // An all-zero control set is a bubble.
    assign s_valid = s_q.we_dst_0 | s_q.we_dst_1 | s_q.mem_we | s_q.mem_re | s_q.halt;
    assign mem_op  = s_valid & (s_q.mem_we | s_q.mem_re);
    assign halted  = (state_q == ST_HALTED);
    // dmem_rdy may arrive in the request cycle, so a zero-wait access never stalls.
    assign stall   = (mem_op & ~dmem_rdy) | halted;
    assign retire  = s_valid & ~stall;

    // Stage register: frozen while stalled, which also covers HALTED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= '0;
        end else if (!stall) begin
            s_q <= s_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                wait_d = '0;
                if (mem_op && !dmem_rdy) begin
                    state_d = ST_MEM_WAIT;
                end else if (s_valid && s_q.halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_rdy) begin
                    wait_d  = '0;
                    // A halt that also carried a memory op retires here.
                    state_d = s_q.halt ? ST_HALTED : ST_IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_HALTED;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = '0;
            end
        endcase
    end

    mwb_wb_mux u_wb_mux (
        .mem_to_reg (s_q.mem_to_reg),
        .pcr_to_reg (s_q.pcr_to_reg),
        .imm_to_reg (s_q.imm_to_reg),
        .alu_to_reg (s_q.alu_to_reg),
        .mem_rdata  (dmem_rdata),
        .pc_return  (s_q.pc_return),
        .load_immd  (s_q.load_immd),
        .alu_result (s_q.alu_result),
        .wrt_data   (wb_data_0)
    );

    assign dst_conflict = s_q.we_dst_0 & s_q.we_dst_1 & (s_q.dst_addr_0 == s_q.dst_addr_1);

    // FSM / datapath outputs
    always_comb begin
        // A simultaneous store and load is treated as a store.
        dmem_we            = s_valid & s_q.mem_we & ~halted;
        dmem_re            = s_valid & s_q.mem_re & ~s_q.mem_we & ~halted;
        dmem_addr          = s_q.mem_addr;
        dmem_wdata         = s_q.mem_wdata;
        MWB_dst_we_0       = s_q.we_dst_0 & ~stall;
        MWB_dst_we_1       = s_q.we_dst_1 & ~stall & ~dst_conflict;
        MWB_dst_addr_0     = s_q.dst_addr_0;
        MWB_dst_addr_1     = s_q.dst_addr_1;
        MWB_reg_0_wrt_data = wb_data_0;
        MWB_reg_1_wrt_data = s_q.reg_data_1;
        MWB_STALL          = stall;
        MWB_halt           = halted;
        MWB_mem_err        = err_q;
        MWB_retired_cnt    = cnt_q;
    end

endmodule

// File: tb/tb_memory_writeback.sv
// tb/tb_memory_writeback.sv - self-checking bench for memory_writeback
module tb_memory_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        DEX_alu_to_reg, DEX_pcr_to_reg, DEX_mem_to_reg, DEX_imm_to_reg;
    logic        DEX_reg_we_dst_0, DEX_reg_we_dst_1, DEX_mem_we, DEX_mem_re, DEX_halt;
    logic [4:0]  DEX_dst_addr_0, DEX_dst_addr_1;
    logic [15:0] DEX_alu_result, DEX_PC_return, DEX_load_immd, DEX_reg_data_1;
    logic [15:0] DEX_mem_read_addr, DEX_mem_write_data;
    logic [15:0] dmem_rdata;
    logic        dmem_rdy;
    logic [15:0] dmem_addr, dmem_wdata;
    logic        dmem_re, dmem_we;
    logic        MWB_dst_we_0, MWB_dst_we_1;
    logic [4:0]  MWB_dst_addr_0, MWB_dst_addr_1;
    logic [15:0] MWB_reg_0_wrt_data, MWB_reg_1_wrt_data;
    logic        MWB_STALL, MWB_halt, MWB_mem_err;
    logic [15:0] MWB_retired_cnt;

    always #5 clk = ~clk;

    memory_writeback #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .DEX_alu_to_reg(DEX_alu_to_reg), .DEX_pcr_to_reg(DEX_pcr_to_reg),
        .DEX_mem_to_reg(DEX_mem_to_reg), .DEX_imm_to_reg(DEX_imm_to_reg),
        .DEX_reg_we_dst_0(DEX_reg_we_dst_0), .DEX_reg_we_dst_1(DEX_reg_we_dst_1),
        .DEX_mem_we(DEX_mem_we), .DEX_mem_re(DEX_mem_re), .DEX_halt(DEX_halt),
        .DEX_dst_addr_0(DEX_dst_addr_0), .DEX_dst_addr_1(DEX_dst_addr_1),
        .DEX_alu_result(DEX_alu_result), .DEX_PC_return(DEX_PC_return),
        .DEX_load_immd(DEX_load_immd), .DEX_reg_data_1(DEX_reg_data_1),
        .DEX_mem_read_addr(DEX_mem_read_addr), .DEX_mem_write_data(DEX_mem_write_data),
        .dmem_rdata(dmem_rdata), .dmem_rdy(dmem_rdy),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_re(dmem_re), .dmem_we(dmem_we),
        .MWB_dst_we_0(MWB_dst_we_0), .MWB_dst_we_1(MWB_dst_we_1),
        .MWB_dst_addr_0(MWB_dst_addr_0), .MWB_dst_addr_1(MWB_dst_addr_1),
        .MWB_reg_0_wrt_data(MWB_reg_0_wrt_data), .MWB_reg_1_wrt_data(MWB_reg_1_wrt_data),
        .MWB_STALL(MWB_STALL), .MWB_halt(MWB_halt), .MWB_mem_err(MWB_mem_err),
        .MWB_retired_cnt(MWB_retired_cnt)
    );

    typedef struct {
        logic        alu_sel, pcr_sel, mem_sel, imm_sel;
        logic        we0, we1, mwe, mre, halt;
        logic [4:0]  a0, a1;
        logic [15:0] alu, pcr, imm, rd1, maddr, wdata;
    } instr_t;

    int vectors = 0;
    int miscompares = 0;
    int exp_cnt = 0;

    // Per-instruction observations collected by run_instr
    int          o_stall, o_re, o_wem, o_w0, o_w1;
    logic [4:0]  o_a0, o_a1;
    logic [15:0] o_d0, o_d1, o_addr, o_wdata, o_cnt;

    function automatic instr_t bubble();
        instr_t i;
        i.alu_sel = 0; i.pcr_sel = 0; i.mem_sel = 0; i.imm_sel = 0;
        i.we0 = 0; i.we1 = 0; i.mwe = 0; i.mre = 0; i.halt = 0;
        i.a0 = 5'($urandom); i.a1 = 5'($urandom);
        i.alu = 16'($urandom); i.pcr = 16'($urandom); i.imm = 16'($urandom);
        i.rd1 = 16'($urandom); i.maddr = 16'($urandom); i.wdata = 16'($urandom);
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i = bubble();
        i.alu_sel = 1'($urandom); i.pcr_sel = 1'($urandom);
        i.mem_sel = 1'($urandom); i.imm_sel = 1'($urandom);
        i.we0 = 1'($urandom); i.we1 = 1'($urandom);
        i.mre = ($urandom % 3) == 0;
        i.mwe = ($urandom % 4) == 0;
        if (($urandom % 3) == 0) i.a1 = i.a0;
        return i;
    endfunction

    function automatic bit is_valid(input instr_t i);
        return i.we0 || i.we1 || i.mwe || i.mre || i.halt;
    endfunction

    function automatic bit is_mem(input instr_t i);
        return i.mwe || i.mre;
    endfunction

    // Reference dst_0 value from the source-priority rule.
    function automatic logic [15:0] ref_d0(input instr_t i, input logic [15:0] rdata);
        if (i.mem_sel) return rdata;
        if (i.pcr_sel) return i.pcr;
        if (i.imm_sel) return i.imm;
        return i.alu;
    endfunction

    function automatic bit ref_we1(input instr_t i);
        return i.we1 && !(i.we0 && i.a0 == i.a1);
    endfunction

    task automatic drive(input instr_t i);
        DEX_alu_to_reg = i.alu_sel; DEX_pcr_to_reg = i.pcr_sel;
        DEX_mem_to_reg = i.mem_sel; DEX_imm_to_reg = i.imm_sel;
        DEX_reg_we_dst_0 = i.we0; DEX_reg_we_dst_1 = i.we1;
        DEX_mem_we = i.mwe; DEX_mem_re = i.mre; DEX_halt = i.halt;
        DEX_dst_addr_0 = i.a0; DEX_dst_addr_1 = i.a1;
        DEX_alu_result = i.alu; DEX_PC_return = i.pcr; DEX_load_immd = i.imm;
        DEX_reg_data_1 = i.rd1; DEX_mem_read_addr = i.maddr; DEX_mem_write_data = i.wdata;
    endtask

    // Issue one instruction, answer its memory access after lat wait cycles,
    // and record what the stage does with it.
    task automatic run_instr(input instr_t i, input int lat, input logic [15:0] rdata);
        int n;
        @(negedge clk);
        drive(i);
        dmem_rdy = 1'b0;
        @(posedge clk); #1;
        drive(bubble());
        o_stall = 0; o_re = 0; o_wem = 0; o_w0 = 0; o_w1 = 0;
        o_a0 = 'x; o_a1 = 'x; o_d0 = 'x; o_d1 = 'x; o_addr = 'x; o_wdata = 'x;
        n = is_mem(i) ? lat + 1 : 1;
        for (int k = 0; k < n; k++) begin
            dmem_rdy   = is_mem(i) ? (k == lat) : 1'($urandom);
            dmem_rdata = (k == n - 1) ? rdata : 16'($urandom);
            #1;
            o_stall += int'(MWB_STALL);
            o_re    += int'(dmem_re);
            o_wem   += int'(dmem_we);
            if (dmem_re || dmem_we) begin
                o_addr = dmem_addr; o_wdata = dmem_wdata;
            end
            if (MWB_dst_we_0) begin
                o_w0++; o_a0 = MWB_dst_addr_0; o_d0 = MWB_reg_0_wrt_data;
            end
            if (MWB_dst_we_1) begin
                o_w1++; o_a1 = MWB_dst_addr_1; o_d1 = MWB_reg_1_wrt_data;
            end
            @(posedge clk); #1;
        end
        dmem_rdy = 1'b0;
        o_cnt = MWB_retired_cnt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(bubble());
        dmem_rdy = 1'b0;
        dmem_rdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(bubble());
        dmem_rdy = 1'b1;
        dmem_rdata = 16'hFFFF;
        repeat (3) @(negedge clk);
        vectors++;
        if ({dmem_re, dmem_we, MWB_dst_we_0, MWB_dst_we_1, MWB_STALL, MWB_halt, MWB_mem_err} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got re=%b we=%b w0=%b w1=%b stall=%b halt=%b err=%b, want all 0",
                     dmem_re, dmem_we, MWB_dst_we_0, MWB_dst_we_1, MWB_STALL, MWB_halt, MWB_mem_err);
        end
        vectors++;
        if ({dmem_addr, dmem_wdata, MWB_retired_cnt, MWB_reg_1_wrt_data} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_data: got addr=%h wdata=%h cnt=%h d1=%h, want 0",
                     dmem_addr, dmem_wdata, MWB_retired_cnt, MWB_reg_1_wrt_data);
        end
        rst_n = 1'b1;
        dmem_rdy = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_alu();
        instr_t i;
        i = bubble();
        i.we0 = 1; i.a0 = 5'd3; i.alu = 16'h1234;
        run_instr(i, 0, 16'h0);
        exp_cnt++;
        vectors++;
        if (o_w0 !== 1 || o_a0 !== 5'd3 || o_d0 !== 16'h1234) begin
            miscompares++;
            $display("FAIL alu_write: got n=%0d addr=%0d data=%h, want n=1 addr=3 data=1234", o_w0, o_a0, o_d0);
        end
        vectors++;
        if (o_stall !== 0 || o_w1 !== 0) begin
            miscompares++;
            $display("FAIL alu_side: got stall=%0d w1=%0d, want 0 0", o_stall, o_w1);
        end
        vectors++;
        if (o_cnt !== 16'(exp_cnt)) begin
            miscompares++;
            $display("FAIL alu_cnt: got %0d want %0d", o_cnt, exp_cnt);
        end
    endtask

    task automatic test_load_late();
        instr_t i;
        i = bubble();
        i.mre = 1; i.mem_sel = 1; i.we0 = 1; i.a0 = 5'd9; i.maddr = 16'h0040;
        run_instr(i, 3, 16'hBEEF);
        exp_cnt++;
        vectors++;
        if (o_stall !== 3 || o_re !== 4 || o_wem !== 0 || o_addr !== 16'h0040) begin
            miscompares++;
            $display("FAIL load_wait: got stall=%0d re=%0d we=%0d addr=%h, want 3 4 0 0040",
                     o_stall, o_re, o_wem, o_addr);
        end
        vectors++;
        if (o_w0 !== 1 || o_d0 !== 16'hBEEF || o_a0 !== 5'd9) begin
            miscompares++;
            $display("FAIL load_write: got n=%0d addr=%0d data=%h, want 1 9 beef", o_w0, o_a0, o_d0);
        end
        vectors++;
        if (o_cnt !== 16'(exp_cnt)) begin
            miscompares++;
            $display("FAIL load_cnt: got %0d want %0d", o_cnt, exp_cnt);
        end
    endtask

    task automatic test_dual_same_addr();
        instr_t i;
        i = bubble();
        i.we0 = 1; i.we1 = 1; i.a0 = 5'd7; i.a1 = 5'd7;
        i.rd1 = 16'h5555; i.alu = 16'hAAAA;
        run_instr(i, 0, 16'h0);
        exp_cnt++;
        vectors++;
        if (o_w0 !== 1 || o_d0 !== 16'hAAAA || o_w1 !== 0) begin
            miscompares++;
            $display("FAIL dual_same: got w0=%0d d0=%h w1=%0d, want 1 aaaa 0", o_w0, o_d0, o_w1);
        end
    endtask

    task automatic test_store_load();
        instr_t i;
        i = bubble();
        i.mwe = 1; i.mre = 1; i.maddr = 16'h0010; i.wdata = 16'h00FF;
        run_instr(i, 0, 16'h0);
        exp_cnt++;
        vectors++;
        if (o_wem !== 1 || o_re !== 0 || o_addr !== 16'h0010 || o_wdata !== 16'h00FF || o_stall !== 0) begin
            miscompares++;
            $display("FAIL store_wins: got we=%0d re=%0d addr=%h wdata=%h stall=%0d, want 1 0 0010 00ff 0",
                     o_wem, o_re, o_addr, o_wdata, o_stall);
        end
        vectors++;
        if (o_cnt !== 16'(exp_cnt)) begin
            miscompares++;
            $display("FAIL store_cnt: got %0d want %0d", o_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        instr_t q[$];
        instr_t i;
        for (int k = 0; k < 5; k++) begin
            i = bubble();
            i.we0 = 1; i.a0 = 5'(k + 10); i.alu = 16'($urandom);
            q.push_back(i);
        end
        @(negedge clk);
        dmem_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(q[k]);
            @(posedge clk); #1;
            vectors++;
            if (MWB_dst_we_0 !== 1'b1 || MWB_dst_addr_0 !== q[k].a0 || MWB_reg_0_wrt_data !== q[k].alu) begin
                miscompares++;
                $display("FAIL b2b_%0d: got we=%b addr=%0d data=%h, want 1 %0d %h",
                         k, MWB_dst_we_0, MWB_dst_addr_0, MWB_reg_0_wrt_data, q[k].a0, q[k].alu);
            end
        end
        drive(bubble());
        @(posedge clk); #1;
        exp_cnt += 5;
        vectors++;
        if (MWB_retired_cnt !== 16'(exp_cnt)) begin
            miscompares++;
            $display("FAIL b2b_cnt: got %0d want %0d", MWB_retired_cnt, exp_cnt);
        end
    endtask

    task automatic test_random();
        instr_t i;
        int lat;
        logic [15:0] rd;
        for (int it = 0; it < 40; it++) begin
            i   = rand_instr();
            lat = $urandom_range(0, 3);
            rd  = 16'($urandom);
            run_instr(i, lat, rd);
            if (is_valid(i)) exp_cnt++;
            vectors++;
            if (o_stall !== (is_mem(i) ? lat : 0)) begin
                miscompares++;
                $display("FAIL rnd_stall[%0d]: got %0d want %0d", it, o_stall, is_mem(i) ? lat : 0);
            end
            vectors++;
            if (o_re !== ((i.mre && !i.mwe) ? lat + 1 : 0) || o_wem !== (i.mwe ? lat + 1 : 0)) begin
                miscompares++;
                $display("FAIL rnd_req[%0d]: got re=%0d we=%0d mre=%b mwe=%b lat=%0d", it, o_re, o_wem, i.mre, i.mwe, lat);
            end
            if (is_mem(i)) begin
                vectors++;
                if (o_addr !== i.maddr || o_wdata !== i.wdata) begin
                    miscompares++;
                    $display("FAIL rnd_addr[%0d]: got %h/%h want %h/%h", it, o_addr, o_wdata, i.maddr, i.wdata);
                end
            end
            vectors++;
            if (o_w0 !== int'(i.we0) || (i.we0 && (o_a0 !== i.a0 || o_d0 !== ref_d0(i, rd)))) begin
                miscompares++;
                $display("FAIL rnd_dst0[%0d]: got n=%0d addr=%0d data=%h want n=%0d addr=%0d data=%h",
                         it, o_w0, o_a0, o_d0, i.we0, i.a0, ref_d0(i, rd));
            end
            vectors++;
            if (o_w1 !== int'(ref_we1(i)) || (ref_we1(i) && (o_a1 !== i.a1 || o_d1 !== i.rd1))) begin
                miscompares++;
                $display("FAIL rnd_dst1[%0d]: got n=%0d addr=%0d data=%h want n=%0d addr=%0d data=%h",
                         it, o_w1, o_a1, o_d1, ref_we1(i), i.a1, i.rd1);
            end
            vectors++;
            if (o_cnt !== 16'(exp_cnt)) begin
                miscompares++;
                $display("FAIL rnd_cnt[%0d]: got %0d want %0d", it, o_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        instr_t i;
        i = bubble();
        i.mre = 1; i.mem_sel = 1; i.we0 = 1; i.a0 = 5'd4; i.maddr = 16'h0200;
        @(negedge clk);
        drive(i);
        dmem_rdy = 1'b0;
        @(posedge clk); #1;
        drive(bubble());
        @(posedge clk); #1;
        vectors++;
        if (dmem_re !== 1'b1 || MWB_STALL !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_wait_pre: got re=%b stall=%b, want 1 1", dmem_re, MWB_STALL);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (dmem_re !== 1'b0 || dmem_we !== 1'b0 || MWB_STALL !== 1'b0 || MWB_retired_cnt !== 16'h0 || MWB_dst_we_0 !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_wait_rst: got re=%b we=%b stall=%b cnt=%0d w0=%b, want all 0",
                     dmem_re, dmem_we, MWB_STALL, MWB_retired_cnt, MWB_dst_we_0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        i = bubble();
        i.we0 = 1; i.a0 = 5'd5; i.alu = 16'h0BAD;
        run_instr(i, 0, 16'h0);
        exp_cnt++;
        vectors++;
        if (o_stall !== 0 || o_w0 !== 1 || o_d0 !== 16'h0BAD || o_cnt !== 16'(exp_cnt)) begin
            miscompares++;
            $display("FAIL post_rst_alu: got stall=%0d w0=%0d d0=%h cnt=%0d, want 0 1 0bad %0d",
                     o_stall, o_w0, o_d0, o_cnt, exp_cnt);
        end
    endtask

    task automatic test_timeout();
        instr_t i;
        int early_err, req_cycles, wr;
        i = bubble();
        i.mre = 1; i.mem_sel = 1; i.we0 = 1; i.a0 = 5'd6; i.maddr = 16'h0300;
        @(negedge clk);
        drive(i);
        dmem_rdy = 1'b0;
        @(posedge clk); #1;
        drive(bubble());
        early_err = 0; req_cycles = 0; wr = 0;
        // request cycle plus four wait cycles
        for (int k = 0; k < 5; k++) begin
            early_err  += int'(MWB_mem_err);
            req_cycles += int'(dmem_re && MWB_STALL);
            wr         += int'(MWB_dst_we_0);
            @(posedge clk); #1;
        end
        vectors++;
        if (early_err !== 0 || req_cycles !== 5 || wr !== 0) begin
            miscompares++;
            $display("FAIL timeout_wait: got err_cycles=%0d req_cycles=%0d writes=%0d, want 0 5 0",
                     early_err, req_cycles, wr);
        end
        vectors++;
        if (MWB_mem_err !== 1'b1 || dmem_re !== 1'b0 || MWB_STALL !== 1'b1 || MWB_halt !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_flag: got err=%b re=%b stall=%b halt=%b, want 1 0 1 1",
                     MWB_mem_err, dmem_re, MWB_STALL, MWB_halt);
        end
        dmem_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (MWB_dst_we_0 !== 1'b0 || MWB_retired_cnt !== 16'(exp_cnt) || MWB_mem_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_hold: got w0=%b cnt=%0d err=%b, want 0 %0d 1",
                     MWB_dst_we_0, MWB_retired_cnt, MWB_mem_err, exp_cnt);
        end
        do_reset();
    endtask

    task automatic test_halt();
        instr_t i;
        i = bubble();
        i.halt = 1; i.we0 = 1; i.a0 = 5'd1; i.alu = 16'h7777;
        run_instr(i, 0, 16'h0);
        exp_cnt++;
        vectors++;
        if (o_w0 !== 1 || o_d0 !== 16'h7777 || o_cnt !== 16'(exp_cnt)) begin
            miscompares++;
            $display("FAIL halt_retire: got w0=%0d d0=%h cnt=%0d, want 1 7777 %0d", o_w0, o_d0, o_cnt, exp_cnt);
        end
        vectors++;
        if (MWB_halt !== 1'b1 || MWB_STALL !== 1'b1 || MWB_mem_err !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_flag: got halt=%b stall=%b err=%b, want 1 1 0", MWB_halt, MWB_STALL, MWB_mem_err);
        end
        i = bubble();
        i.we0 = 1; i.we1 = 1; i.a0 = 5'd2; i.a1 = 5'd3; i.mwe = 1;
        run_instr(i, 0, 16'h0);
        vectors++;
        if (o_w0 !== 0 || o_w1 !== 0 || o_wem !== 0 || o_stall !== 1 || o_cnt !== 16'(exp_cnt)) begin
            miscompares++;
            $display("FAIL halt_ignore: got w0=%0d w1=%0d memwe=%0d stall=%0d cnt=%0d, want 0 0 0 1 %0d",
                     o_w0, o_w1, o_wem, o_stall, o_cnt, exp_cnt);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_late();
        test_dual_same_addr();
        test_store_load();
        test_back_to_back();
        test_random();
        test_reset_mid_wait();
        test_timeout();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
